// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse receive path and the VGA painter.
package ps2_mouse_pkg;

    localparam int FRAME_BITS = 11;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Byte-0 field positions of a standard 3-byte mouse packet.
    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_DATA   = 2'd1,
        FS_PARITY = 2'd2,
        FS_STOP   = 2'd3
    } frame_state_t;

    // Limit a signed candidate coordinate to 0..lim-1.
    function automatic logic [9:0] clamp_coord(input logic signed [11:0] v, input int lim);
        logic signed [11:0] hi;
        hi = 12'(lim - 1);
        if (v[11])
            return '0;
        else if (v > hi)
            return 10'(hi);
        else
            return 10'(v);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronizers, ps2_clk glitch
// filter, 11-bit frame FSM and idle timeout.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   FS_IDLE   | waiting for a start bit (0)
//   FS_DATA   | shifting in 8 data bits, LSB first
//   FS_PARITY | capturing the odd-parity bit
//   FS_STOP   | checking the stop bit, then report byte/error
module ps2_rx_frame
    import ps2_mouse_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       pkt_abort
);

    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYC);

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_s;
    logic            data_s;
    logic            clk_filt;
    logic [FC_W-1:0] filt_cnt;
    logic            strobe;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            timeout;
    frame_state_t    state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Filtered clock falls on the cycle the last of FILT_LEN low samples arrives.
    assign strobe = clk_filt && !clk_s && (filt_cnt == FILT_LAST);

    assign to_hit    = (to_cnt == TO_LIMIT);
    assign timeout   = to_hit && !strobe && ((state != FS_IDLE) || pkt_busy);
    assign pkt_abort = timeout;

    // The shift register holds the byte until the next frame's data bits.
    assign rx_byte = shreg;

    // Two-flop synchronizers; PS/2 lines idle high.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: level follows clk_s only after FILT_LEN equal samples.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Idle counter: cleared by every strobe, saturates at the timeout limit.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (strobe)
            to_cnt <= '0;
        else if (!to_hit)
            to_cnt <= to_cnt + 1'b1;
    end

    // Frame FSM, advancing one step per bit strobe; timeout returns it to idle.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (strobe) begin
                case (state)
                    FS_IDLE: begin
                        if (!data_s) begin
                            state   <= FS_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    FS_DATA: begin
                        shreg <= {data_s, shreg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= FS_PARITY;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    FS_PARITY: begin
                        par_bit <= data_s;
                        state   <= FS_STOP;
                    end
                    default: begin
                        state <= FS_IDLE;
                        if (data_s && (^{shreg, par_bit}))
                            byte_valid <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                endcase
            end else if (timeout) begin
                state     <= FS_IDLE;
                frame_err <= (state != FS_IDLE);
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse pointer tracker: assembles 3-byte movement packets and keeps a
// clamped on-screen pointer position plus left/right button levels.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] xm,
    output logic [9:0] ym,
    output logic       btn_left,
    output logic       btn_right,
    output logic       pkt_valid,
    output logic       frame_err
);

    logic [7:0]         rx_byte;
    logic               byte_valid;
    logic               rx_err;
    logic               pkt_abort;
    logic [1:0]         pkt_idx;
    logic               hdr_left;
    logic               hdr_right;
    logic               hdr_xsign;
    logic               hdr_ysign;
    logic               hdr_xovf;
    logic               hdr_yovf;
    logic [7:0]         dx_byte;
    logic signed [11:0] dx_ext;
    logic signed [11:0] dy_ext;
    logic signed [11:0] x_next;
    logic signed [11:0] y_next;

    ps2_rx_frame #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pkt_busy   (pkt_idx != 2'd0),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_err),
        .pkt_abort  (pkt_abort)
    );

    assign frame_err = rx_err;

    // 9-bit deltas sign-extended to 12 bits; dy comes straight from the byte on the wire.
    assign dx_ext = {{4{hdr_xsign}}, dx_byte};
    assign dy_ext = {{4{hdr_ysign}}, rx_byte};
    assign x_next = $signed({2'b00, xm}) + dx_ext;
    assign y_next = $signed({2'b00, ym}) - dy_ext;

    // Packet assembly and pointer/button update on the third byte.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            pkt_idx   <= 2'd0;
            hdr_left  <= 1'b0;
            hdr_right <= 1'b0;
            hdr_xsign <= 1'b0;
            hdr_ysign <= 1'b0;
            hdr_xovf  <= 1'b0;
            hdr_yovf  <= 1'b0;
            dx_byte   <= '0;
            xm        <= 10'(H_RES / 2);
            ym        <= 10'(V_RES / 2);
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            pkt_valid <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            if (rx_err || pkt_abort) begin
                pkt_idx <= 2'd0;
            end else if (byte_valid) begin
                case (pkt_idx)
                    2'd0: begin
                        // Bytes without the always-one sync bit are dropped to resync.
                        if (rx_byte[B0_SYNC]) begin
                            hdr_left  <= rx_byte[B0_LEFT];
                            hdr_right <= rx_byte[B0_RIGHT];
                            hdr_xsign <= rx_byte[B0_XSIGN];
                            hdr_ysign <= rx_byte[B0_YSIGN];
                            hdr_xovf  <= rx_byte[B0_XOVF];
                            hdr_yovf  <= rx_byte[B0_YOVF];
                            pkt_idx   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_byte <= rx_byte;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        pkt_idx <= 2'd0;
                        if (!hdr_xovf)
                            xm <= clamp_coord(x_next, H_RES);
                        if (!hdr_yovf)
                            ym <= clamp_coord(y_next, V_RES);
                        btn_left  <= hdr_left;
                        btn_right <= hdr_right;
                        pkt_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: a packet-level reference model
// pushes expected pointer states, a monitor pops them on each pkt_valid.
module tb_ps2_mouse_tracker;

    localparam int H         = 640;
    localparam int V         = 480;
    localparam int FILT      = 8;
    localparam int TO        = 600;
    localparam int HALF      = 20;
    localparam int SHORT_GAP = 30;
    localparam int LONG_GAP  = 2 * TO;

    logic       clk_100MHz = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [9:0] xm;
    logic [9:0] ym;
    logic       btn_left;
    logic       btn_right;
    logic       pkt_valid;
    logic       frame_err;

    always #5 clk_100MHz = ~clk_100MHz;

    ps2_mouse_tracker #(
        .H_RES       (H),
        .V_RES       (V),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .xm         (xm),
        .ym         (ym),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .pkt_valid  (pkt_valid),
        .frame_err  (frame_err)
    );

    typedef struct {
        int x;
        int y;
        int btn;
    } pkt_t;

    pkt_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_err  = 0;
    int   seen_err = 0;

    // Reference model state: pointer, buttons and bytes collected so far.
    int         mx, my, mbtn;
    int         midx;
    logic [7:0] mb0, mb1;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        mx   = H / 2;
        my   = V / 2;
        mbtn = 0;
        midx = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int   dx, dy;
        pkt_t p;
        if (midx == 0) begin
            if (b[3]) begin
                mb0  = b;
                midx = 1;
            end
        end else if (midx == 1) begin
            mb1  = b;
            midx = 2;
        end else begin
            dx = mb0[4] ? int'(mb1) - 256 : int'(mb1);
            dy = mb0[5] ? int'(b) - 256 : int'(b);
            if (!mb0[6]) mx = clampi(mx + dx, 0, H - 1);
            if (!mb0[7]) my = clampi(my - dy, 0, V - 1);
            mbtn  = {30'd0, mb0[0], mb0[1]};
            p.x   = mx;
            p.y   = my;
            p.btn = mbtn;
            exp_q.push_back(p);
            midx = 0;
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            cyc(5);
            ps2_clk = 1'b0;
            cyc(FILT - 4);
            ps2_clk = 1'b1;
            cyc(HALF - 5 - (FILT - 4));
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // One byte on the wire; the expectation is registered before the bits go out.
    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_bit);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (bad_par) begin
            exp_err++;
            midx = 0;
        end else begin
            model_byte(b);
        end
        for (int i = 0; i < 11; i++) send_bit(fr[i], i == glitch_bit);
        ps2_data = 1'b1;
        cyc(SHORT_GAP);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int bad_idx, input int glitch_byte);
        send_byte(b0, bad_idx == 0, glitch_byte == 0 ? 4 : -1);
        send_byte(b1, bad_idx == 1, glitch_byte == 1 ? 4 : -1);
        send_byte(b2, bad_idx == 2, glitch_byte == 2 ? 4 : -1);
    endtask

    // Idle longer than the timeout: any partial packet is forgotten.
    task automatic long_idle();
        midx = 0;
        cyc(LONG_GAP);
    endtask

    task automatic check_pos(input string name, input int x, input int y, input int btn);
        check_eq({name, "_x"}, int'(xm), x);
        check_eq({name, "_y"}, int'(ym), y);
        check_eq({name, "_btn"}, int'({btn_left, btn_right}), btn);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int         kind;

        // Monitor: pops one expectation per pkt_valid and counts frame_err pulses.
        fork
            begin
                logic prev_pv;
                pkt_t e;
                prev_pv = 1'b0;
                forever begin
                    @(negedge clk_100MHz);
                    if (rst_n) begin
                        if (pkt_valid) begin
                            check_eq("pkt_valid_width", int'(prev_pv), 0);
                            if (exp_q.size() == 0) begin
                                check_eq("pkt_unexpected", exp_q.size(), 1);
                            end else begin
                                e = exp_q.pop_front();
                                check_eq("pkt_x", int'(xm), e.x);
                                check_eq("pkt_y", int'(ym), e.y);
                                check_eq("pkt_btn", int'({btn_left, btn_right}), e.btn);
                            end
                        end
                        if (frame_err) seen_err++;
                        prev_pv = pkt_valid;
                    end else begin
                        prev_pv = 1'b0;
                    end
                end
            end
        join_none

        model_reset();
        cyc(4);
        rst_n = 1'b1;
        cyc(5);
        check_pos("reset", 320, 240, 0);
        check_eq("reset_pkt_valid", int'(pkt_valid), 0);
        check_eq("reset_frame_err", int'(frame_err), 0);

        // Basic move: +5 right, +3 up.
        send_packet(8'h08, 8'h05, 8'h03, -1, -1);
        check_pos("basic", 325, 237, 0);

        // Walk to x=10, then dx=-256 with left button clamps to 0.
        send_packet(8'h18, 8'h00, 8'h00, -1, -1);
        send_packet(8'h18, 8'hC5, 8'h00, -1, -1);
        check_pos("walk", 10, 237, 0);
        send_packet(8'h19, 8'h00, 8'h00, -1, -1);
        check_pos("clamp_left", 0, 237, 2);

        // Bad parity on byte 1: error, no update; next good packet applies.
        send_packet(8'h08, 8'h10, 8'h10, 1, -1);
        long_idle();
        check_eq("parity_err_count", seen_err, exp_err);
        check_pos("after_parity", 0, 237, 2);
        send_packet(8'h08, 8'h20, 8'h10, -1, -1);
        check_pos("recover", 32, 221, 0);

        // Header without sync bit is dropped silently.
        send_byte(8'h00, 1'b0, -1);
        send_packet(8'h09, 8'h05, 8'h05, -1, -1);
        check_pos("resync", 37, 216, 2);
        check_eq("resync_err_count", seen_err, exp_err);

        // Frame abandoned after 5 bits: one timeout error, then normal operation.
        exp_err++;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        long_idle();
        check_eq("timeout_err_count", seen_err, exp_err);
        send_packet(8'h0A, 8'h01, 8'h01, -1, -1);
        check_pos("after_timeout", 38, 215, 1);

        // Short clock glitch inside byte 1 does not disturb the frame.
        send_packet(8'h08, 8'h03, 8'h00, -1, 1);
        check_pos("glitch", 41, 215, 0);
        send_packet(8'h48, 8'h7F, 8'h02, -1, -1);
        check_pos("x_overflow", 41, 213, 0);

        // Reset mid-frame restores the centre position.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        cyc(3);
        model_reset();
        rst_n = 1'b1;
        cyc(5);
        check_pos("mid_reset", 320, 240, 0);

        // Randomized packets with occasional parity errors, junk headers and aborts.
        for (int n = 0; n < 14; n++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) r0[7:6] = 2'b00;
            kind = int'($urandom_range(0, 7));
            case (kind)
                0: begin
                    send_packet(r0, r1, r2, int'($urandom_range(0, 2)), -1);
                    long_idle();
                end
                1: begin
                    send_byte(r1 & 8'hF7, 1'b0, -1);
                    send_packet(r0, r1, r2, -1, -1);
                end
                2: begin
                    send_byte(r0, 1'b0, -1);
                    if ($urandom_range(0, 1) != 0) send_byte(r1, 1'b0, -1);
                    long_idle();
                    send_packet(r0, r1, r2, -1, -1);
                end
                default: send_packet(r0, r1, r2, -1, -1);
            endcase
        end

        cyc(100);
        check_eq("pending_packets", exp_q.size(), 0);
        check_eq("frame_err_total", seen_err, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
